compuertas_logicas: RTL and testbench
=====================================

Name: compuertas_logicas

Overview:
Basic logic-gate unit. Computes AND, OR, NOT, NAND, NOR, XOR and XNOR of two operand vectors A and B and presents all seven results on registered outputs. Serves as the reference gate bank for the lab datapath and as the leaf cell for gate-level exercises. Operands are sampled on the rising clock edge; results follow one cycle later.

Parameters:
WIDTH, 1, bit width of operands A, B and of every result output.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operands A/B valid this cycle; sample when high
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out_valid  output  1  results registered from a valid sample
D  output  WIDTH  A AND B
O  output  WIDTH  A OR B
NT  output  WIDTH  NOT A
ND  output  WIDTH  NOT (A AND B)
NR  output  WIDTH  NOT (A OR B)
XR  output  WIDTH  A XOR B
XN  output  WIDTH  NOT (A XOR B)

Interface is fixed as follows: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- All operations are bitwise, per bit index i in 0..WIDTH-1. No carries and no cross-bit interaction.
- NT depends only on A. B has no effect on NT.
- Reset: while rst_n=0, all outputs are forced immediately to 0, including out_valid and all seven result buses. This holds regardless of clk.
- Reset deassertion is taken synchronously. The first capture happens on the first rising edge of clk after rst_n goes high.
- On each rising clk edge with in_valid=1:
  - all seven results are computed from the current A and B and registered;
  - out_valid is set to 1 on the next cycle.
- Latency is exactly 1 cycle from sample edge to output.
- On a rising edge with in_valid=0:
  - result registers hold their previous values;
  - out_valid goes to 0.
- Back-to-back valid samples give back-to-back results at one per cycle. There is no backpressure and no stall input.
- Reset asserted mid-stream clears everything at once. A sample in flight is discarded and no stale result appears after reset is released.
- Invariants on every registered result: ND = ~D, NR = ~O, XN = ~XR.
- The outputs have no combinational path from A or B.

Decomposition:
- Shared package compuertas_pkg:
  - default WIDTH constant;
  - typedef for the result bundle, a struct of the seven WIDTH-wide fields D, O, NT, ND, NR, XR, XN.
- Sub-module compuertas_logicas_core: a purely combinational gate bank, with A and B in and the result struct out.
- The top level instantiates the core and adds the valid-gated result register plus the out_valid flop.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> all outputs 0. Then assert rst_n=0 asynchronously between edges while outputs are nonzero -> outputs 0 immediately.
- Truth table, WIDTH=1, one valid sample per cycle, checked 1 cycle later:
  - A=0,B=0 -> D0 O0 NT1 ND1 NR1 XR0 XN1;
  - A=1,B=0 -> D0 O1 NT0 ND1 NR0 XR1 XN0;
  - A=0,B=1 -> D0 O1 NT1 ND1 NR0 XR1 XN0;
  - A=1,B=1 -> D1 O1 NT0 ND0 NR0 XR0 XN1.
- Hold behaviour: a valid sample with A=1,B=1, then in_valid=0 with A=0,B=0 -> results stay D=1,XN=1 and out_valid drops to 0.
- Wide operands, WIDTH=8, A=8'hF0, B=8'hCC -> D=8'hC0 O=8'hFC NT=8'h0F ND=8'h3F NR=8'h03 XR=8'h3C XN=8'hC3.
- Streaming: 16 consecutive random valid samples -> out_valid high for 16 cycles, each result matches its sample delayed by 1 cycle, and the invariants ND=~D, NR=~O, XN=~XR hold every cycle.
- Reset mid-stream: assert rst_n low while in_valid=1, release, keep in_valid=0 -> out_valid stays 0 and results stay 0.

Source files
------------

// File: rtl/compuertas_pkg.sv
// ============================================================================
// compuertas_pkg : shared width constants, result bundle and gate helper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package compuertas_pkg;

  localparam int WIDTH_DEFAULT = 1;
  // Widest operand the result bundle can carry; instances slice down to WIDTH.
  localparam int MAX_WIDTH     = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t d;
    word_t o;
    word_t nt;
    word_t nd;
    word_t nr;
    word_t xr;
    word_t xn;
  } gates_t;

  function automatic gates_t eval_gates(input word_t a, input word_t b);
    gates_t g;
    g.d  = a & b;
    g.o  = a | b;
    g.nt = ~a;
    g.nd = ~(a & b);
    g.nr = ~(a | b);
    g.xr = a ^ b;
    g.xn = ~(a ^ b);
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/compuertas_logicas_core.sv
// ============================================================================
// compuertas_logicas_core : purely combinational bitwise gate bank
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module compuertas_logicas_core
  import compuertas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output gates_t           res
);

  word_t w_a_ext;
  word_t w_b_ext;

  // Operands are zero-extended into the bundle width; only the low WIDTH
  // bits of each field are meaningful to the caller.
  always_comb begin
    w_a_ext             = '0;
    w_b_ext             = '0;
    w_a_ext[WIDTH-1:0]  = a;
    w_b_ext[WIDTH-1:0]  = b;
    res                 = eval_gates(w_a_ext, w_b_ext);
  end

endmodule

`default_nettype wire

// File: rtl/compuertas_logicas.sv
// ============================================================================
// compuertas_logicas : registered AND/OR/NOT/NAND/NOR/XOR/XNOR gate unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module compuertas_logicas
  import compuertas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] NT,
  output logic [WIDTH-1:0] ND,
  output logic [WIDTH-1:0] NR,
  output logic [WIDTH-1:0] XR,
  output logic [WIDTH-1:0] XN
);

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] nt;
    logic [WIDTH-1:0] nd;
    logic [WIDTH-1:0] nr;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] xn;
  } res_t;

  gates_t w_gates;
  res_t   w_next;
  res_t   r_res;
  logic   r_valid;

  compuertas_logicas_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (A),
    .b   (B),
    .res (w_gates)
  );

  always_comb begin
    w_next.d  = w_gates.d [WIDTH-1:0];
    w_next.o  = w_gates.o [WIDTH-1:0];
    w_next.nt = w_gates.nt[WIDTH-1:0];
    w_next.nd = w_gates.nd[WIDTH-1:0];
    w_next.nr = w_gates.nr[WIDTH-1:0];
    w_next.xr = w_gates.xr[WIDTH-1:0];
    w_next.xn = w_gates.xn[WIDTH-1:0];
  end

  // Padding bits above WIDTH carry no information; fold them away here.
  if (WIDTH < MAX_WIDTH) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{w_gates.d [MAX_WIDTH-1:WIDTH], w_gates.o [MAX_WIDTH-1:WIDTH],
                         w_gates.nt[MAX_WIDTH-1:WIDTH], w_gates.nd[MAX_WIDTH-1:WIDTH],
                         w_gates.nr[MAX_WIDTH-1:WIDTH], w_gates.xr[MAX_WIDTH-1:WIDTH],
                         w_gates.xn[MAX_WIDTH-1:WIDTH]};
  end

  // Results hold across idle cycles; only out_valid reflects the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_next;
      end
    end
  end

  assign out_valid = r_valid;
  assign D         = r_res.d;
  assign O         = r_res.o;
  assign NT        = r_res.nt;
  assign ND        = r_res.nd;
  assign NR        = r_res.nr;
  assign XR        = r_res.xr;
  assign XN        = r_res.xn;

endmodule

`default_nettype wire

// File: tb/tb_compuertas_logicas.sv
// ============================================================================
// tb_compuertas_logicas : scoreboard bench for the registered gate unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compuertas_logicas;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d, o, nt, nd, nr, xr, xn;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a_in, b_in;
  logic         out_valid;
  logic [W-1:0] d_o, o_o, nt_o, nd_o, nr_o, xr_o, xn_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last_exp;
  exp_t zero_exp;

  always #5 clk = ~clk;

  compuertas_logicas #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .D         (d_o),
    .O         (o_o),
    .NT        (nt_o),
    .ND        (nd_o),
    .NR        (nr_o),
    .XR        (xr_o),
    .XN        (xn_o)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d  = a & b;
    e.o  = a | b;
    e.nt = ~a;
    e.nd = ~(a & b);
    e.nr = ~(a | b);
    e.xr = a ^ b;
    e.xn = ~(a ^ b);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input exp_t e);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".D"},  64'(d_o),  64'(e.d));
    chk({tag, ".O"},  64'(o_o),  64'(e.o));
    chk({tag, ".NT"}, 64'(nt_o), 64'(e.nt));
    chk({tag, ".ND"}, 64'(nd_o), 64'(e.nd));
    chk({tag, ".NR"}, 64'(nr_o), 64'(e.nr));
    chk({tag, ".XR"}, 64'(xr_o), 64'(e.xr));
    chk({tag, ".XN"}, 64'(xn_o), 64'(e.xn));
  endtask

  // Drive on the falling edge, check 1 ns after the capturing rising edge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    if (v) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 64'd0, 64'd1);
      end else begin
        e        = sb.pop_front();
        last_exp = e;
        check_out(tag, 1'b1, e);
      end
    end else begin
      check_out(tag, 1'b0, last_exp);
    end
  endtask

  initial begin
    int vcount;
    zero_exp = '{default: '0};
    last_exp = zero_exp;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;

    // Reset held across edges, with inputs active
    a_in = 8'hA5; b_in = 8'h3C; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 1'b0, zero_exp);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Truth table with all bits replicated
    cycle("tt00", 1'b1, 8'h00, 8'h00);
    cycle("tt10", 1'b1, 8'hFF, 8'h00);
    cycle("tt01", 1'b1, 8'h00, 8'hFF);
    cycle("tt11", 1'b1, 8'hFF, 8'hFF);

    // Hold: idle cycle keeps the last results, drops out_valid
    cycle("hold_s", 1'b1, 8'hFF, 8'hFF);
    cycle("hold_i", 1'b0, 8'h00, 8'h00);
    chk("hold.D_const",  64'(d_o),  64'hFF);
    chk("hold.XN_const", 64'(xn_o), 64'hFF);

    // Wide operands with literal expectations
    cycle("wide", 1'b1, 8'hF0, 8'hCC);
    chk("wide.D_c",  64'(d_o),  64'hC0);
    chk("wide.O_c",  64'(o_o),  64'hFC);
    chk("wide.NT_c", 64'(nt_o), 64'h0F);
    chk("wide.ND_c", 64'(nd_o), 64'h3F);
    chk("wide.NR_c", 64'(nr_o), 64'h03);
    chk("wide.XR_c", 64'(xr_o), 64'h3C);
    chk("wide.XN_c", 64'(xn_o), 64'hC3);

    // Streaming: 16 back-to-back random samples
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("stream%0d", i), 1'b1, W'($urandom), W'($urandom));
      if (out_valid === 1'b1) vcount++;
    end
    chk("stream.count", 64'(vcount), 64'd16);
    cycle("stream_end", 1'b0, 8'h00, 8'h00);

    // Asynchronous reset between edges while outputs are nonzero
    cycle("pre_arst", 1'b1, 8'hF0, 8'hCC);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, zero_exp);
    sb.delete();
    last_exp = zero_exp;

    // Reset mid-stream: a sample in flight must be discarded
    @(negedge clk);
    rst_n = 1'b1;
    cycle("mid_pre", 1'b1, 8'h5A, 8'h0F);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'hFF;
    b_in     = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_arst", 1'b0, zero_exp);
    last_exp = zero_exp;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("post_rst%0d", i), 1'b0, 8'hFF, 8'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
